instr_mem_loader: RTL and testbench

//  Writer side of the instruction path: accepts symbolic instructions (mnemonic + fields) over a

---
 rtl/instr_mem_loader_pkg.sv | 53 +++++
 rtl/instr_mem_loader_encoder.sv | 38 +++
 rtl/instr_mem_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction loader: mnemonic codes, MIPS opcode/funct values
// (the same set the main control decodes) and the loader FSM state encoding.
package instr_mem_loader_pkg;

    localparam logic [3:0] MNEM_ADD   = 4'd0;
    localparam logic [3:0] MNEM_ADDU  = 4'd1;
    localparam logic [3:0] MNEM_SUB   = 4'd2;
    localparam logic [3:0] MNEM_SUBU  = 4'd3;
    localparam logic [3:0] MNEM_ADDI  = 4'd4;
    localparam logic [3:0] MNEM_ADDIU = 4'd5;
    localparam logic [3:0] MNEM_LW    = 4'd6;
    localparam logic [3:0] MNEM_SW    = 4'd7;
    localparam logic [3:0] MNEM_BEQ   = 4'd8;
    localparam logic [3:0] MNEM_J     = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_ADD  = 6'd32;
    localparam logic [5:0] FUNCT_ADDU = 6'd33;
    localparam logic [5:0] FUNCT_SUB  = 6'd34;
    localparam logic [5:0] FUNCT_SUBU = 6'd35;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
`ifdef LOADER_PAD_EN
        ST_PAD    = 3'd3,
`endif
        ST_DONE   = 3'd4
    } loaderState_e;

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encJ(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/instr_mem_loader_encoder.sv
// Combinational encoder: symbolic mnemonic + fields -> 32-bit MIPS word, with a legal flag
// for mnemonic codes 10-15.
module instr_encoder
    import instr_mem_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the encoding format per mnemonic; fields a format does not use are ignored.
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (mnem)
            MNEM_ADD:   word = encR(rs, rt, rd, FUNCT_ADD);
            MNEM_ADDU:  word = encR(rs, rt, rd, FUNCT_ADDU);
            MNEM_SUB:   word = encR(rs, rt, rd, FUNCT_SUB);
            MNEM_SUBU:  word = encR(rs, rt, rd, FUNCT_SUBU);
            MNEM_ADDI:  word = encI(OP_ADDI, rs, rt, imm);
            MNEM_ADDIU: word = encI(OP_ADDIU, rs, rt, imm);
            MNEM_LW:    word = encI(OP_LW, rs, rt, imm);
            MNEM_SW:    word = encI(OP_SW, rs, rt, imm);
            MNEM_BEQ:   word = encI(OP_BEQ, rs, rt, imm);
            MNEM_J:     word = encJ(target);
            default: begin
                word  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: streams symbolic instructions in, writes encoded words sequentially.
// Optional LOADER_PAD_EN: after the last word, fill the rest of memory with NOPs (32'h0).
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_last,
    input  logic [3:0]        i_mnem,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [15:0]       i_imm,
    input  logic [25:0]       i_target,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_count,
    output logic              o_err
);

    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] MAX_PTR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    loaderState_e      state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              last_r;
    logic [31:0]       encWord_s;
    logic              encLegal_s;
    logic              accept_s;
    logic              atTop_s;

    assign accept_s = i_valid & o_ready;
    assign atTop_s  = (ptr_r == MAX_PTR);

    instr_encoder u_encoder (
        .mnem   (i_mnem),
        .rs     (i_rs),
        .rt     (i_rt),
        .rd     (i_rd),
        .imm    (i_imm),
        .target (i_target),
        .word   (encWord_s),
        .legal  (encLegal_s)
    );

    // Session FSM; ptr_r always holds the next address to be written.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= BASE_PTR;
            last_r      <= 1'b0;
            o_ready     <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= {ADDR_W{1'b0}};
            o_mem_wdata <= 32'h0000_0000;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_count     <= {(ADDR_W + 1){1'b0}};
            o_err       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        ptr_r   <= BASE_PTR;
                        o_count <= {(ADDR_W + 1){1'b0}};
                        o_err   <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                        state_r <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (accept_s) begin
                        if (encLegal_s) begin
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= ptr_r;
                            o_mem_wdata <= encWord_s;
                            last_r      <= i_last;
                            o_ready     <= 1'b0;
                            state_r     <= ST_WRITE;
                        end else begin
                            // Illegal mnemonic is consumed without a write.
                            o_err <= 1'b1;
                            if (i_last) begin
                                o_ready <= 1'b0;
                                o_done  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    o_mem_we <= 1'b0;
                    ptr_r    <= ptr_r + PTR_ONE;
                    o_count  <= o_count + CNT_ONE;
                    if (last_r) begin
`ifdef LOADER_PAD_EN
                        if (!atTop_s) begin
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= ptr_r + PTR_ONE;
                            o_mem_wdata <= 32'h0000_0000;
                            state_r     <= ST_PAD;
                        end else begin
                            o_done  <= 1'b1;
                            state_r <= ST_DONE;
                        end
`else
                        o_done  <= 1'b1;
                        state_r <= ST_DONE;
`endif
                    end else if (atTop_s) begin
                        // Memory full with more words pending: end rather than wrap.
                        o_err   <= 1'b1;
                        o_done  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        o_ready <= 1'b1;
                        state_r <= ST_ACCEPT;
                    end
                end
`ifdef LOADER_PAD_EN
                ST_PAD: begin
                    ptr_r   <= ptr_r + PTR_ONE;
                    o_count <= o_count + CNT_ONE;
                    if (atTop_s) begin
                        o_mem_we <= 1'b0;
                        o_done   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        o_mem_addr <= ptr_r + PTR_ONE;
                    end
                end
`endif
                ST_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_ready  <= 1'b0;
                    o_mem_we <= 1'b0;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes queued at handshake, checked on o_mem_we.
module tb_instr_mem_loader;

    localparam int ADDR_W    = 5;
    localparam int BASE_ADDR = 0;
    localparam int MAX_A     = (1 << ADDR_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              valid = 1'b0;
    logic              ready;
    logic              last = 1'b0;
    logic [3:0]        mnem = 4'd0;
    logic [4:0]        rs = 5'd0;
    logic [4:0]        rt = 5'd0;
    logic [4:0]        rd = 5'd0;
    logic [15:0]       imm = 16'd0;
    logic [25:0]       tgt = 26'd0;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err;

    wr_t expQ[$];
    wr_t monE;
    int  vecCnt = 0;
    int  missCnt = 0;
    int  doneCnt = 0;
    int  doneSnap = 0;
    int  modelPtr = BASE_ADDR;
    int  modelCount = 0;
    bit  modelErr = 1'b0;
    bit  modelOpen = 1'b0;

    instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_last      (last),
        .i_mnem      (mnem),
        .i_rs        (rs),
        .i_rt        (rt),
        .i_rd        (rd),
        .i_imm       (imm),
        .i_target    (tgt),
        .o_mem_we    (memWe),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) doneCnt++;
            if (memWe) begin
                if (expQ.size() == 0) begin
                    chk("unexpected write", {32'd0, memWdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    monE = expQ.pop_front();
                    chk("write addr", 64'(memAddr), 64'(monE.a));
                    chk("write data", 64'(memWdata), 64'(monE.d));
                end
            end
        end
    end

    task automatic startSession();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        modelPtr   = BASE_ADDR;
        modelCount = 0;
        modelErr   = 1'b0;
        modelOpen  = 1'b1;
        doneSnap   = doneCnt;
        chk("err cleared on start", 64'(err), 64'd0);
        chk("busy after start", 64'(busy), 64'd1);
    endtask

    task automatic sendWord(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                            input bit lst, input logic [31:0] expWord);
        bit acc = 1'b0;
        bit gone = 1'b0;
        bit expAcc = modelOpen;
        for (int i = 0; i < 20 && !acc && !gone; i++) begin
            if (ready) begin
                mnem = m; rs = s; rt = t; rd = d; imm = im; tgt = tg;
                last = lst; valid = 1'b1; acc = 1'b1;
                if (expAcc) begin
                    if (m <= 4'd9) begin
                        expQ.push_back(wr_t'{a: ADDR_W'(modelPtr), d: expWord});
                        modelCount++;
                        if (lst) begin
`ifdef LOADER_PAD_EN
                            for (int a = modelPtr + 1; a <= MAX_A; a++) begin
                                expQ.push_back(wr_t'{a: ADDR_W'(a), d: 32'h0});
                                modelCount++;
                            end
`endif
                            modelOpen = 1'b0;
                        end else if (modelPtr == MAX_A) begin
                            modelErr  = 1'b1;
                            modelOpen = 1'b0;
                        end
                        modelPtr++;
                    end else begin
                        modelErr = 1'b1;
                        if (lst) modelOpen = 1'b0;
                    end
                end
                @(negedge clk);
                valid = 1'b0;
                last  = 1'b0;
            end else if (!busy) begin
                gone = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("word accepted", 64'(acc), 64'(expAcc));
    endtask

    task automatic endSession();
        int n = 0;
        while (doneCnt == doneSnap && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done pulses", 64'(doneCnt - doneSnap), 64'd1);
        @(negedge clk);
        chk("done one cycle", 64'(done), 64'd0);
        chk("idle after done", 64'(busy), 64'd0);
        chk("count", 64'(count), 64'(modelCount));
        chk("err", 64'(err), 64'(modelErr));
        chk("queue drained", 64'(expQ.size()), 64'd0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset we", 64'(memWe), 64'd0);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset count", 64'(count), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset addr", 64'(memAddr), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // add rd=3,rs=1,rt=2 alone
        startSession();
        sendWord(4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h0, 1'b1, 32'h0022_1820);
        endSession();

        // addi/lw/sw with an ignored mid-session start and an illegal mnemonic in between
        startSession();
        sendWord(4'd4, 5'd0, 5'd1, 5'd0, 16'd5, 26'h0, 1'b0, 32'h2001_0005);
        pulseStart();
        sendWord(4'd15, 5'd7, 5'd7, 5'd7, 16'd7, 26'h7, 1'b0, 32'h0);
        sendWord(4'd6, 5'd1, 5'd2, 5'd9, 16'd4, 26'h0, 1'b0, 32'h8C22_0004);
        sendWord(4'd7, 5'd0, 5'd2, 5'd0, 16'd8, 26'h0, 1'b1, 32'hAC02_0008);
        endSession();

        // beq then j
        startSession();
        sendWord(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 32'h1022_FFFF);
        sendWord(4'd9, 5'd31, 5'd31, 5'd31, 16'h1234, 26'h10, 1'b1, 32'h0800_0010);
        endSession();

        // remaining R-type funct codes and addiu
        startSession();
        sendWord(4'd1, 5'd4, 5'd5, 5'd7, 16'hFFFF, 26'h0, 1'b0, 32'h0085_3821);
        sendWord(4'd2, 5'd31, 5'd0, 5'd31, 16'h0, 26'h3FFFFFF, 1'b0, 32'h03E0_F822);
        sendWord(4'd5, 5'd3, 5'd4, 5'd0, 16'h8000, 26'h0, 1'b0, 32'h2464_8000);
        sendWord(4'd3, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0, 1'b1, 32'h0043_0823);
        endSession();

        // illegal mnemonic as the last item: no write, err set
        startSession();
        sendWord(4'd12, 5'd1, 5'd1, 5'd1, 16'd1, 26'h1, 1'b1, 32'h0);
        endSession();

        // overflow: one more word than memory holds, never marked last
        startSession();
        for (int i = 0; i <= MAX_A + 1; i++) begin
            sendWord(4'd5, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3 + 1), 26'h0, 1'b0,
                     {6'd9, 5'(i), 5'(i + 1), 16'(i * 3 + 1)});
        end
        endSession();

        // async reset while a write is on the bus
        startSession();
        sendWord(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0022_1820);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset mid-write we", 64'(memWe), 64'd0);
        chk("reset mid-write busy", 64'(busy), 64'd0);
        chk("reset mid-write ready", 64'(ready), 64'd0);
        chk("reset mid-write queue", 64'(expQ.size()), 64'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // single word after reset
        startSession();
        sendWord(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2A, 1'b1, 32'h0800_002A);
        endSession();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
